// File: rtl/axi_slv_wr_pkg.sv
// ----------------------------------------------------------------------------
// axi_slv_wr_pkg
// Shared types and constants for the AXI write-slave memory endpoint.
//   burst_e        : AW_BURST encoding (FIXED/INCR/WRAP/RSVD)
//   RESP_OKAY/SLVERR : B_RESP encodings
//   state_e        : write FSM states (IDLE -> DATA -> RESP)
//   wrap_len_legal : true when a WRAP burst length (beats-1) is 1, 3, 7 or 15
// ----------------------------------------------------------------------------
package axi_slv_wr_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Largest legal AW_SIZE for a 32-bit data path (4 bytes per beat).
   localparam int MAX_SIZE = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Bit n set means a WRAP burst with AW_LEN == n is legal (2, 4, 8, 16 beats).
   localparam logic [15:0] WRAP_LEN_OK = 16'h808A;

   function automatic logic wrap_len_legal(input logic [3:0] len);
      return WRAP_LEN_OK[len];
   endfunction

endpackage

// File: rtl/axi_slv_wr_addr_gen.sv
// ----------------------------------------------------------------------------
// axi_slv_wr_addr_gen
// Purely combinational next-beat address generator and burst legality check.
// Ports:
//   i_start   : burst start byte address (as captured from AW)
//   i_cur     : byte address of the beat being accepted now
//   i_len     : beats minus 1
//   i_size    : log2(bytes per beat)
//   i_burst   : burst type (FIXED/INCR/WRAP/RSVD)
//   o_next    : byte address of the following beat
//   o_illegal : burst cannot be serviced (size too big, reserved type,
//               or WRAP with an unsupported length)
// ----------------------------------------------------------------------------
module axi_slv_wr_addr_gen
   import axi_slv_wr_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int SIZE       = 3
) (
   input  logic [ADDR_WIDTH-1:0] i_start,
   input  logic [ADDR_WIDTH-1:0] i_cur,
   input  logic [SIZE:0]         i_len,
   input  logic [SIZE-1:0]       i_size,
   input  logic [SIZE-2:0]       i_burst,
   output logic [ADDR_WIDTH-1:0] o_next,
   output logic                  o_illegal
);

   localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);
   localparam logic [SIZE-1:0]       MAX_SZ = SIZE'(MAX_SIZE);

   logic [ADDR_WIDTH-1:0] w_bytes;
   logic [ADDR_WIDTH-1:0] w_window;
   logic [ADDR_WIDTH-1:0] w_lower;
   logic [ADDR_WIDTH-1:0] w_incr;

   always_comb begin
      w_bytes  = ONE << i_size;
      // WRAP window is (LEN+1)*bytes; LEN+1 is a power of two whenever the
      // burst is legal, so the window mask below is a clean alignment mask.
      w_window = (ADDR_WIDTH'(i_len) + ONE) << i_size;
      w_lower  = i_start & ~(w_window - ONE);
      w_incr   = i_cur + w_bytes;

      o_next = i_cur;
      case (burst_e'(i_burst))
         BURST_FIXED: o_next = i_cur;
         BURST_INCR:  o_next = w_incr;
         BURST_WRAP:  o_next = (w_incr == (w_lower + w_window)) ? w_lower : w_incr;
         default:     o_next = i_cur;
      endcase

      o_illegal = (i_size > MAX_SZ)
               || (burst_e'(i_burst) == BURST_RSVD)
               || ((burst_e'(i_burst) == BURST_WRAP) && !wrap_len_legal(i_len));
   end

endmodule

// File: rtl/axi_slv_wr_mem.sv
// ----------------------------------------------------------------------------
// axi_slv_wr_mem
// AXI write-channel slave with a word-addressed internal memory. Accepts one
// burst at a time on AW/W, commits beats under byte strobes and returns a
// single B response. A registered debug port reads memory words directly.
//
// Handshake rule (all three channels): a transfer happens on a rising ACLK
// edge where both VALID and READY are 1. READY/BVALID are registered and
// decoded from FSM state only; they never depend combinationally on inputs.
//
// Ports:
//   ACLK, ARESETn          : clock, synchronous active-low reset
//   AW_ADDR_q/ID/LEN/BURST/SIZE, AWVALID/AWREADY : write address channel
//   W_DATA/STRB/LAST/ID, WVALID/WREADY           : write data channel (W_ID ignored)
//   B_ID/B_RESP, BVALID/BREADY                   : write response channel
//   dbg_addr / dbg_data    : debug word index / registered word read
// ----------------------------------------------------------------------------
module axi_slv_wr_mem
   import axi_slv_wr_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SIZE       = 3,
   parameter int DEPTH      = 256
) (
   input  logic                     ACLK,
   input  logic                     ARESETn,
   input  logic [ADDR_WIDTH-1:0]    AW_ADDR_q,
   input  logic [SIZE:0]            AW_ID,
   input  logic [SIZE:0]            AW_LEN,
   input  logic [SIZE-2:0]          AW_BURST,
   input  logic [SIZE-1:0]          AW_SIZE,
   input  logic                     AWVALID,
   output logic                     AWREADY,
   input  logic [DATA_WIDTH-1:0]    W_DATA,
   input  logic [SIZE:0]            W_STRB,
   input  logic                     W_LAST,
   input  logic [SIZE:0]            W_ID,
   input  logic                     WVALID,
   output logic                     WREADY,
   output logic [SIZE:0]            B_ID,
   output logic [SIZE-2:0]          B_RESP,
   output logic                     BVALID,
   input  logic                     BREADY,
   input  logic [$clog2(DEPTH)-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0]    dbg_data
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int WORD_W = ADDR_WIDTH - 2;
   localparam int LANES  = DATA_WIDTH / 8;

   // FSM and captured burst context
   state_e                r_state;
   logic                  r_awready;
   logic                  r_wready;
   logic                  r_bvalid;
   logic [SIZE:0]         r_id;
   logic [SIZE-2:0]       r_bresp;
   logic [ADDR_WIDTH-1:0] r_start;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [SIZE:0]         r_len;
   logic [SIZE-2:0]       r_burst;
   logic [SIZE-1:0]       r_size;
   logic [SIZE:0]         r_beat;
   logic                  r_err;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_dbg;

   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic                  w_illegal;
   logic [WORD_W-1:0]     w_word;
   logic                  w_in_range;
   logic                  w_w_hs;
   logic                  w_last_beat;
   logic                  w_beat_err;
   logic                  w_mem_we;
   logic                  w_unused_wid;

   axi_slv_wr_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .SIZE       (SIZE)
   ) u_addr_gen (
      .i_start   (r_start),
      .i_cur     (r_addr),
      .i_len     (r_len),
      .i_size    (r_size),
      .i_burst   (r_burst),
      .o_next    (w_next_addr),
      .o_illegal (w_illegal)
   );

   assign w_unused_wid = ^W_ID;

   assign w_word      = r_addr[ADDR_WIDTH-1:2];
   assign w_in_range  = (w_word < WORD_W'(DEPTH));
   assign w_w_hs      = r_wready & WVALID;
   assign w_last_beat = (r_beat == r_len);
   // Beat-level error sources: illegal burst, address past the array, or
   // W_LAST not matching the beat count. The beat count alone ends the burst.
   assign w_beat_err  = w_illegal | ~w_in_range | (W_LAST != w_last_beat);
   // Reset wins over an in-flight beat so nothing is committed on a reset edge.
   assign w_mem_we    = w_w_hs & ARESETn & ~w_illegal & w_in_range;

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_state   <= ST_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_id      <= '0;
         r_bresp   <= RESP_OKAY;
         r_start   <= '0;
         r_addr    <= '0;
         r_len     <= '0;
         r_burst   <= '0;
         r_size    <= '0;
         r_beat    <= '0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_awready <= 1'b1;
               if (AWVALID && r_awready) begin
                  r_id      <= AW_ID;
                  r_start   <= AW_ADDR_q;
                  r_addr    <= AW_ADDR_q;
                  r_len     <= AW_LEN;
                  r_burst   <= AW_BURST;
                  r_size    <= AW_SIZE;
                  r_beat    <= '0;
                  r_err     <= 1'b0;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
                  r_state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_w_hs) begin
                  r_beat <= r_beat + 1'b1;
                  r_addr <= w_next_addr;
                  r_err  <= r_err | w_beat_err;
                  if (w_last_beat) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_bresp  <= (r_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                     r_state  <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (r_bvalid && BREADY) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_awready <= 1'b0;
               r_wready  <= 1'b0;
               r_bvalid  <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   // Storage is not reset. The debug read samples the pre-write contents,
   // so a same-cycle write to the same word shows the old value.
   always_ff @(posedge ACLK) begin
      if (w_mem_we) begin
         for (int b = 0; b < LANES; b++) begin
            if (W_STRB[b]) begin
               r_mem[w_word[IDX_W-1:0]][8*b +: 8] <= W_DATA[8*b +: 8];
            end
         end
      end
      r_dbg <= r_mem[dbg_addr];
   end

   assign AWREADY  = r_awready;
   assign WREADY   = r_wready;
   assign BVALID   = r_bvalid;
   assign B_ID     = r_id;
   assign B_RESP   = r_bresp;
   assign dbg_data = r_dbg;

endmodule

// File: tb/tb_axi_slv_wr_mem.sv
// ----------------------------------------------------------------------------
// tb_axi_slv_wr_mem
// Self-checking bench for axi_slv_wr_mem. A behavioural memory model computes
// beat addresses arithmetically (WRAP by modulo over the window) and applies
// strobes; a compare process checks dbg_data and B responses every cycle.
// ----------------------------------------------------------------------------
module tb_axi_slv_wr_mem;

   localparam int DEPTH = 256;

   // ---------------- clock / reset ----------------
   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   always #5 ACLK = ~ACLK;

   logic [31:0] AW_ADDR_q = '0;
   logic [3:0]  AW_ID = '0;
   logic [3:0]  AW_LEN = '0;
   logic [1:0]  AW_BURST = '0;
   logic [2:0]  AW_SIZE = '0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] W_DATA = '0;
   logic [3:0]  W_STRB = '0;
   logic        W_LAST = 1'b0;
   logic [3:0]  W_ID = '0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [3:0]  B_ID;
   logic [1:0]  B_RESP;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic [7:0]  dbg_addr = '0;
   logic [31:0] dbg_data;

   axi_slv_wr_mem #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .SIZE       (3),
      .DEPTH      (DEPTH)
   ) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .AW_ADDR_q (AW_ADDR_q),
      .AW_ID     (AW_ID),
      .AW_LEN    (AW_LEN),
      .AW_BURST  (AW_BURST),
      .AW_SIZE   (AW_SIZE),
      .AWVALID   (AWVALID),
      .AWREADY   (AWREADY),
      .W_DATA    (W_DATA),
      .W_STRB    (W_STRB),
      .W_LAST    (W_LAST),
      .W_ID      (W_ID),
      .WVALID    (WVALID),
      .WREADY    (WREADY),
      .B_ID      (B_ID),
      .B_RESP    (B_RESP),
      .BVALID    (BVALID),
      .BREADY    (BREADY),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   // ---------------- scoreboard state ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [5:0]  exp_q[$];          // {B_ID, B_RESP} per completed burst
   logic [31:0] exp_mem [DEPTH];
   bit          exp_known [DEPTH];
   logic [31:0] beat_data [16];
   logic [3:0]  beat_strb [16];
   int unsigned mw_word [16];
   bit          mw_wr [16];
   logic [1:0]  m_resp;
   int          hot_word = 0;
   bit          dbg_force = 1'b0;
   int          dbg_force_addr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // ---------------- reference model ----------------
   task automatic model_burst(input logic [31:0] start, input logic [3:0] len,
                              input logic [1:0] bt, input logic [2:0] size,
                              input int bad_last);
      longint unsigned bytes, window, lower, a, st;
      bit illegal, err;
      st      = longint'(start);
      bytes   = longint'(1) << size;
      window  = (longint'(len) + 1) * bytes;
      illegal = (size > 3'd2) || (bt == 2'b11) ||
                (bt == 2'b10 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
      err     = illegal || (bad_last >= 0);
      lower   = st - (st % window);
      for (int i = 0; i <= int'(len); i++) begin
         case (bt)
            2'b00:   a = st;
            2'b10:   a = lower + ((st - lower + longint'(i) * bytes) % window);
            default: a = st + longint'(i) * bytes;
         endcase
         mw_word[i] = int'(a >> 2);
         mw_wr[i]   = !illegal && ((a >> 2) < DEPTH);
         if (!illegal && ((a >> 2) >= DEPTH)) err = 1'b1;
      end
      m_resp = err ? 2'b10 : 2'b00;
   endtask

   task automatic model_apply(input int i);
      int w;
      if (mw_wr[i]) begin
         w = int'(mw_word[i]);
         for (int b = 0; b < 4; b++)
            if (beat_strb[i][b]) exp_mem[w][8*b +: 8] = beat_data[i][8*b +: 8];
         if (beat_strb[i] == 4'hF) exp_known[w] = 1'b1;
      end
   endtask

   // ---------------- driver ----------------
   task automatic burst(input logic [31:0] start, input logic [3:0] id, input logic [3:0] len,
                        input logic [1:0] bt, input logic [2:0] size, input int bad_last,
                        input int bready_wait, input bit aw_pending, input int abort_at);
      int gap;
      model_burst(start, len, bt, size, bad_last);
      if (abort_at < 0) exp_q.push_back({id, m_resp});
      check("awready_idle", AWREADY, 1);
      AW_ADDR_q = start; AW_ID = id; AW_LEN = len; AW_BURST = bt; AW_SIZE = size;
      AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      AW_ADDR_q = $urandom; AW_ID = 4'($urandom); AW_LEN = 4'($urandom);
      check("aw_to_wready", WREADY, 1);
      check("awready_busy", AWREADY, 0);
      check("bvalid_data", BVALID, 0);
      for (int i = 0; i <= int'(len); i++) begin
         gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
         repeat (gap) begin
            AWVALID = 1'($urandom_range(0, 1));
            tick();
            check("wready_gap", WREADY, 1);
            check("awready_gap", AWREADY, 0);
         end
         AWVALID = 1'b0;
         hot_word = int'(mw_word[i] % DEPTH);
         if (i == abort_at) begin
            ARESETn = 1'b0;
            tick();
            check("abort_wready", WREADY, 0);
            check("abort_bvalid", BVALID, 0);
            check("abort_awready_rst", AWREADY, 0);
            tick();
            ARESETn = 1'b1;
            tick();
            check("abort_awready", AWREADY, 1);
            check("abort_no_b", BVALID, 0);
            return;
         end
         W_DATA = beat_data[i]; W_STRB = beat_strb[i];
         W_LAST = (i == int'(len)) ^ (i == bad_last);
         W_ID = 4'($urandom);
         WVALID = 1'b1;
         tick();
         WVALID = 1'b0;
         model_apply(i);
         if (i < int'(len)) begin
            check("wready_mid", WREADY, 1);
            check("bvalid_mid", BVALID, 0);
         end else begin
            check("wready_end", WREADY, 0);
            check("bvalid_end", BVALID, 1);
         end
      end
      for (int k = 0; k < bready_wait; k++) begin
         AWVALID = aw_pending;
         tick();
         check("bvalid_hold", BVALID, 1);
         check("awready_resp", AWREADY, 0);
      end
      AWVALID = 1'b0;
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      check("bvalid_clear", BVALID, 0);
      check("b_to_awready", AWREADY, 1);
   endtask

   task automatic peek(input int w);
      dbg_force_addr = w;
      dbg_force = 1'b1;
      repeat (3) tick();
      dbg_force = 1'b0;
   endtask

   // ---------------- compare process ----------------
   initial begin
      logic [31:0] snap_val;
      bit          snap_known;
      forever begin
         @(posedge ACLK);
         snap_val   = exp_mem[dbg_addr];
         snap_known = exp_known[dbg_addr];
         @(negedge ACLK);
         if (snap_known) check("dbg_data", dbg_data, snap_val);
         if (BVALID) begin
            if (exp_q.size() == 0) begin
               check("b_unexpected", {31'd0, BVALID}, 32'd0);
            end else begin
               check("b_id", B_ID, exp_q[0][5:2]);
               check("b_resp", B_RESP, exp_q[0][1:0]);
               if (BREADY) void'(exp_q.pop_front());
            end
         end
         if (dbg_force) dbg_addr = 8'(dbg_force_addr);
         else if ($urandom_range(0, 1) == 1) dbg_addr = 8'(hot_word);
         else dbg_addr = 8'($urandom_range(0, DEPTH - 1));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [3:0]  r_len;
      logic [1:0]  r_bt;
      logic [2:0]  r_size;
      logic [31:0] r_start;
      int          r_bad;
      for (int w = 0; w < DEPTH; w++) begin
         exp_mem[w] = '0;
         exp_known[w] = 1'b0;
      end

      // reset
      repeat (3) tick();
      check("rst_awready", AWREADY, 0);
      check("rst_wready", WREADY, 0);
      check("rst_bvalid", BVALID, 0);
      check("rst_bid", B_ID, 0);
      check("rst_bresp", B_RESP, 0);
      ARESETn = 1'b1;
      tick();
      check("awready_after_rst", AWREADY, 1);

      // fill all memory so every word has a known value
      for (int k = 0; k < DEPTH / 16; k++) begin
         for (int i = 0; i < 16; i++) begin
            beat_data[i] = $urandom;
            beat_strb[i] = 4'hF;
         end
         burst(32'(k * 64), 4'(k), 4'd15, 2'b01, 3'd2, -1, 0, 1'b0, -1);
      end

      // INCR: words 4..7
      for (int i = 0; i < 4; i++) begin
         beat_data[i] = 32'hA0 + 32'(i);
         beat_strb[i] = 4'hF;
      end
      burst(32'h10, 4'd5, 4'd3, 2'b01, 3'd2, -1, 0, 1'b0, -1);
      check("pin_incr_w4", exp_mem[4], 32'hA0);
      check("pin_incr_w7", exp_mem[7], 32'hA3);
      check("pin_incr_resp", m_resp, 2'b00);
      for (int w = 4; w < 8; w++) peek(w);

      // WRAP: start 0x18 -> words 6, 7, 4, 5
      for (int i = 0; i < 4; i++) begin
         beat_data[i] = 32'hD0 + 32'(i);
         beat_strb[i] = 4'hF;
      end
      burst(32'h18, 4'd2, 4'd3, 2'b10, 3'd2, -1, 0, 1'b0, -1);
      check("pin_wrap_w6", exp_mem[6], 32'hD0);
      check("pin_wrap_w7", exp_mem[7], 32'hD1);
      check("pin_wrap_w4", exp_mem[4], 32'hD2);
      check("pin_wrap_w5", exp_mem[5], 32'hD3);
      check("pin_wrap_resp", m_resp, 2'b00);
      for (int w = 4; w < 8; w++) peek(w);

      // FIXED: byte merge into word 2
      beat_data[0] = 32'h0; beat_strb[0] = 4'hF;
      burst(32'h08, 4'd1, 4'd0, 2'b01, 3'd2, -1, 0, 1'b0, -1);
      beat_data[0] = 32'h000000AA; beat_strb[0] = 4'h1;
      beat_data[1] = 32'h0000BB00; beat_strb[1] = 4'h2;
      beat_data[2] = 32'h00CC0000; beat_strb[2] = 4'h4;
      burst(32'h08, 4'd7, 4'd2, 2'b00, 3'd2, -1, 0, 1'b0, -1);
      check("pin_fixed_w2", exp_mem[2], 32'h00CCBBAA);
      check("pin_fixed_resp", m_resp, 2'b00);
      peek(2);

      // error: AW_SIZE = 3
      beat_data[0] = 32'hDEADBEEF; beat_strb[0] = 4'hF;
      burst(32'h20, 4'd3, 4'd0, 2'b01, 3'd3, -1, 0, 1'b0, -1);
      check("pin_size_resp", m_resp, 2'b10);
      peek(8);

      // error: second beat past last word
      beat_data[0] = 32'h11111111; beat_strb[0] = 4'hF;
      beat_data[1] = 32'h22222222; beat_strb[1] = 4'hF;
      burst(32'(4 * (DEPTH - 1)), 4'd6, 4'd1, 2'b01, 3'd2, -1, 0, 1'b0, -1);
      check("pin_oor_w255", exp_mem[DEPTH - 1], 32'h11111111);
      check("pin_oor_resp", m_resp, 2'b10);
      peek(DEPTH - 1);

      // BREADY held low for 5 cycles with a pending AW
      beat_data[0] = 32'h5555AAAA; beat_strb[0] = 4'hF;
      beat_data[1] = 32'hAAAA5555; beat_strb[1] = 4'hF;
      burst(32'h40, 4'd9, 4'd1, 2'b01, 3'd2, -1, 5, 1'b1, -1);

      // reset after 2 of 4 beats
      for (int i = 0; i < 4; i++) begin
         beat_data[i] = 32'hC0DE0000 + 32'(i);
         beat_strb[i] = 4'hF;
      end
      burst(32'h80, 4'hC, 4'd3, 2'b01, 3'd2, -1, 0, 1'b0, 2);
      check("pin_abort_w32", exp_mem[32], 32'hC0DE0000);
      check("pin_abort_w33", exp_mem[33], 32'hC0DE0001);
      peek(32);
      peek(33);
      peek(34);

      // randomized bursts
      for (int r = 0; r < 40; r++) begin
         r_bt   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         r_size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         r_len  = 4'($urandom_range(0, 15));
         if (r_bt == 2'b10 && $urandom_range(0, 3) != 0)
            r_len = 4'((1 << $urandom_range(1, 4)) - 1);
         r_start = 32'($urandom_range(0, 300)) << r_size;
         r_bad   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(r_len)) : -1;
         for (int i = 0; i < 16; i++) begin
            beat_data[i] = $urandom;
            beat_strb[i] = 4'($urandom);
         end
         burst(r_start, 4'($urandom), r_len, r_bt, r_size, r_bad,
               $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
      end

      repeat (4) tick();
      check("b_queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axi_slv_wr_mem.md
# axi_slv_wr_mem

AXI write-channel slave endpoint with a word-addressed internal memory. It accepts one write burst at a time on the AW/W channels, commits beats to storage under byte strobes, and returns a single B response. It is the RTL DUT driven by the slave-side write traffic of the AXI environment. A debug read port lets the bench inspect memory contents without using AXI read channels.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; fixed at 32 in this block
- SIZE, 3, channel sizing base: ID/LEN are SIZE+1 bits, BURST/RESP are SIZE-1 bits, AW_SIZE is SIZE bits, STRB is SIZE+1 bits
- DEPTH, 256, memory depth in 32-bit words
- ACLK  in  1  clock; one clock domain
- ARESETn  in  1  synchronous, active-low reset
- AW_ADDR_q  in  ADDR_WIDTH  burst start byte address
- AW_ID  in  4  transaction ID
- AW_LEN  in  4  beats minus 1
- AW_BURST  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AW_SIZE  in  3  bytes per beat = 2^AW_SIZE
- AWVALID / AWREADY  in / out  1  address handshake
- W_DATA  in  32  write data
- W_STRB  in  4  byte strobes
- W_LAST  in  1  final-beat marker
- W_ID  in  4  write data ID; ignored
- WVALID / WREADY  in / out  1  data handshake
- B_ID  out  4  response ID
- B_RESP  out  2  00 OKAY, 10 SLVERR
- BVALID / BREADY  out / in  1  response handshake
- dbg_addr  in  log2(DEPTH)  debug word index
- dbg_data  out  32  word at dbg_addr, registered

## Operation
- The FSM has three states: IDLE, DATA, RESP.
- IDLE: AWREADY=1. On AWVALID&&AWREADY:
  - capture ID, ADDR, LEN, BURST, SIZE; clear the error flag and beat counter.
  - move to DATA.
- DATA: WREADY=1. Each beat accepted on WVALID&&WREADY:
  - writes every byte lane whose strobe is set to mem[addr>>2].
  - increments the beat counter and advances addr.
  - after beat LEN+1 is accepted, move to RESP.
- RESP: BVALID=1, B_ID=captured ID, B_RESP = error ? 10 : 00. On BVALID&&BREADY, move to IDLE.
- Address advance, with bytes = 2^AW_SIZE:
  - FIXED: address held constant.
  - INCR: addr + bytes.
  - WRAP: addr + bytes, wrapped inside the aligned window of (LEN+1)*bytes bytes. lower = start & ~(window-1); when next == lower+window, next = lower.
- Conditions that set SLVERR (the burst is still fully consumed):
  - AW_SIZE > 2, or AW_BURST == 11, or WRAP with LEN not in {1, 3, 7, 15}: no beats are written.
  - beat word index >= DEPTH: that beat is dropped; other beats are written normally.
  - W_LAST disagrees with the beat count: W_LAST=1 before beat LEN+1, or W_LAST=0 on beat LEN+1. The beat is still written; the beat count alone ends the burst.
- Memory is not reset.
- dbg_data = mem[dbg_addr], one cycle after dbg_addr is presented. If the debug read and an AXI write hit the same word in the same cycle, dbg_data returns the old value.

## Timing
- Reset values (while ARESETn=0 at a clock edge, and on the cycle after): state IDLE, AWREADY=0 during reset, WREADY=0, BVALID=0, B_ID=0, B_RESP=00, error flag and counter 0. AWREADY=1 from the first cycle with ARESETn=1.
- AWREADY, WREADY and BVALID are decoded from the state register only, so no input-to-output combinational path exists.
- AW handshake at edge N gives WREADY=1 in cycle N+1.
- The last W handshake at edge M gives WREADY=0 and BVALID=1 in cycle M+1.
- B handshake at edge K gives AWREADY=1 in cycle K+1.
- Minimum burst occupancy: LEN+3 cycles from AW acceptance to the next AWREADY.
- BVALID, B_ID and B_RESP stay stable until BREADY.
- AWVALID during DATA or RESP is not accepted.
- WVALID during IDLE or RESP is not accepted.
- Reset mid-burst returns the block to IDLE immediately. Words already written are kept, and no B response is issued for the aborted burst.

## Structure
- Package axi_slv_wr_pkg holds:
  - burst enum (FIXED/INCR/WRAP/RSVD) and resp constants (OKAY=2'b00, SLVERR=2'b10).
  - state enum (IDLE/DATA/RESP) and the legal WRAP length set.
- Sub-module axi_slv_wr_addr_gen is purely combinational: start addr, cur addr, len, size and burst in; next addr and illegal-burst flag out.
- Memory is an inferred register array inside axi_slv_wr_mem.

## Test plan
- INCR: AW addr 0x10, ID 5, LEN 3, SIZE 2; data A0..A3, strb F -> mem[4..7] = A0..A3. BVALID rises the cycle after beat 4, with B_ID=5, B_RESP=00.
- WRAP: addr 0x18, LEN 3, SIZE 2; data D0..D3 -> D0..D3 land in words 6, 7, 4, 5; B_RESP=00.
- FIXED: pre-write word 2 = 0. Then addr 0x08, LEN 2, beats 0x000000AA/strb 1, 0x0000BB00/strb 2, 0x00CC0000/strb 4 -> mem[2] = 0x00CCBBAA; B_RESP=00.
- Errors:
  - AW_SIZE=3, LEN 0 -> one beat consumed, memory unchanged, B_RESP=10.
  - INCR at word DEPTH-1, LEN 1 -> first beat written, second dropped, B_RESP=10.
- BREADY held low for 5 cycles -> BVALID/B_ID/B_RESP stable throughout, AWREADY stays 0, and a pending AWVALID is accepted only the cycle after the B handshake.
- Reset asserted after 2 of 4 INCR beats -> next cycle WREADY=0, BVALID=0; AWREADY=1 after release; the first two words are retained and no B response appears.
